// File: rtl/wavelet_sample_loader.sv
// ---------------------------------------------------------------------------
// wavelet_sample_loader
//
// Front-end producer for the wavelet FIR bank. Each accepted signed sample is
// shifted into a NUM_ELEM-deep window that drives the `taps` bus of every fir
// instance. o_start_calc pulses whenever a fresh window is ready. The first
// pulse comes once the window has been primed. After that, one pulse is
// issued per DECIMATE accepts.
//
// Build option:
//   WAVELET_SYNC_INPUT_EN  - when defined, i_data_valid is an asynchronous pin.
//                            It is passed through a 2-flop synchronizer and a
//                            rising-edge detect, so one accept is produced per
//                            strobe. When undefined, every cycle in which
//                            i_data_valid is high is one accept.
//
// Ports:
//   clk           clock
//   rst           synchronous, active-high reset
//   i_data        signed sample (two's complement), stored as-is
//   i_data_valid  sample strobe
//   i_flush       clears the window and returns to priming; wins over accept
//   o_taps        sample window, element i at [BITS_PER_ELEM*i +: BITS_PER_ELEM],
//                 element 0 newest
//   o_start_calc  one-cycle pulse, aligned with the o_taps update
//   o_primed      high once NUM_ELEM samples were accepted since reset/flush
//
// Legal parameter ranges: NUM_ELEM >= 2, 1 <= DECIMATE <= 255.
// ---------------------------------------------------------------------------
module wavelet_sample_loader #(
    parameter int BITS_PER_ELEM = 8,
    parameter int NUM_ELEM      = 7,
    parameter int DECIMATE      = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [BITS_PER_ELEM-1:0]          i_data,
    input  logic                              i_data_valid,
    input  logic                              i_flush,
    output logic [NUM_ELEM*BITS_PER_ELEM-1:0] o_taps,
    output logic                              o_start_calc,
    output logic                              o_primed
);

    localparam int TAPS_W = NUM_ELEM * BITS_PER_ELEM;
    localparam int FILL_W = $clog2(NUM_ELEM) + 1;

    // Compare against the value before the increment, so the accept that
    // brings the count to NUM_ELEM (or DECIMATE) is the one that fires.
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(NUM_ELEM - 1);
    localparam logic [7:0]        DEC_LAST  = 8'(DECIMATE - 1);

    typedef enum logic {
        FILL,
        RUN
    } state_t;

    state_t            state;
    logic [FILL_W-1:0] fill_cnt;
    logic [7:0]        dec_cnt;
    logic              accept;

`ifdef WAVELET_SYNC_INPUT_EN
    logic valid_meta;
    logic valid_sync;
    logic valid_sync_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_meta   <= 1'b0;
            valid_sync   <= 1'b0;
            valid_sync_d <= 1'b0;
        end else begin
            valid_meta   <= i_data_valid;
            valid_sync   <= valid_meta;
            valid_sync_d <= valid_sync;
        end
    end

    // The sender holds i_data stable long enough for the sample to be taken
    // directly at the accept edge, so i_data itself is not synchronized.
    assign accept = valid_sync & ~valid_sync_d;
`else
    assign accept = i_data_valid;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= FILL;
            fill_cnt     <= '0;
            dec_cnt      <= '0;
            o_taps       <= '0;
            o_start_calc <= 1'b0;
            o_primed     <= 1'b0;
        end else begin
            o_start_calc <= 1'b0;
            if (i_flush) begin
                state    <= FILL;
                fill_cnt <= '0;
                dec_cnt  <= '0;
                o_taps   <= '0;
                o_primed <= 1'b0;
            end else if (accept) begin
                o_taps <= {o_taps[TAPS_W-BITS_PER_ELEM-1:0], i_data};
                case (state)
                    FILL: begin
                        fill_cnt <= fill_cnt + 1'b1;
                        if (fill_cnt == FILL_LAST) begin
                            state        <= RUN;
                            o_primed     <= 1'b1;
                            o_start_calc <= 1'b1;
                            dec_cnt      <= '0;
                        end
                    end
                    RUN: begin
                        if (dec_cnt == DEC_LAST) begin
                            o_start_calc <= 1'b1;
                            dec_cnt      <= '0;
                        end else begin
                            dec_cnt <= dec_cnt + 1'b1;
                        end
                    end
                    default: state <= FILL;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wavelet_sample_loader.sv
// ---------------------------------------------------------------------------
// Bench for wavelet_sample_loader. Two instances share one stimulus stream:
// dut1 uses DECIMATE=1 and dut3 uses DECIMATE=3. The reference model keeps
// the window as a plain array and tracks the number of samples accepted since
// the last clear. The expected pulse is derived arithmetically from that
// count. In the synchronizer build, an accept is modelled as landing on the
// third edge after the strobe rise.
// ---------------------------------------------------------------------------
module tb_wavelet_sample_loader;

    localparam int BPE = 8;
    localparam int NE  = 7;
    localparam int TW  = NE * BPE;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [BPE-1:0] data = '0;
    logic          valid = 1'b0;
    logic          flush = 1'b0;

    logic [TW-1:0] taps1, taps3;
    logic          calc1, calc3, primed1, primed3;

    wavelet_sample_loader #(.BITS_PER_ELEM(BPE), .NUM_ELEM(NE), .DECIMATE(1)) dut1 (
        .clk(clk), .rst(rst), .i_data(data), .i_data_valid(valid), .i_flush(flush),
        .o_taps(taps1), .o_start_calc(calc1), .o_primed(primed1)
    );

    wavelet_sample_loader #(.BITS_PER_ELEM(BPE), .NUM_ELEM(NE), .DECIMATE(3)) dut3 (
        .clk(clk), .rst(rst), .i_data(data), .i_data_valid(valid), .i_flush(flush),
        .o_taps(taps3), .o_start_calc(calc3), .o_primed(primed3)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [BPE-1:0] win [NE];
    int             n_acc = 0;
    logic           exp_calc1 = 1'b0, exp_calc3 = 1'b0;
    logic           prev_v = 1'b0;
    logic [1:0]     rise_pipe = 2'b00;

    function automatic logic pulse_due(input int n, input int d);
        return (n == NE) || (n > NE && ((n - NE) % d) == 0);
    endfunction

    function automatic logic [TW-1:0] exp_taps();
        logic [TW-1:0] t;
        t = '0;
        for (int i = 0; i < NE; i++) t[BPE*i +: BPE] = win[i];
        return t;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NE; i++) win[i] = '0;
        n_acc = 0;
    endtask

    // Drive one cycle of inputs, advance the model over the edge, then check.
    task automatic step(input logic v, input logic [BPE-1:0] d, input logic f, input logic r);
        logic acc;
        valid = v; data = d; flush = f; rst = r;
        @(posedge clk);
`ifdef WAVELET_SYNC_INPUT_EN
        if (r) begin
            acc = 1'b0; prev_v = 1'b0; rise_pipe = 2'b00;
        end else begin
            acc          = rise_pipe[1];
            rise_pipe[1] = rise_pipe[0];
            rise_pipe[0] = v & ~prev_v;
            prev_v       = v;
        end
`else
        acc = v;
`endif
        exp_calc1 = 1'b0;
        exp_calc3 = 1'b0;
        if (r || f) begin
            model_clear();
        end else if (acc) begin
            for (int i = NE - 1; i > 0; i--) win[i] = win[i-1];
            win[0] = d;
            n_acc++;
            exp_calc1 = pulse_due(n_acc, 1);
            exp_calc3 = pulse_due(n_acc, 3);
        end
        #1;
        check_val("taps1",   64'(taps1),   64'(exp_taps()));
        check_val("calc1",   64'(calc1),   64'(exp_calc1));
        check_val("primed1", 64'(primed1), 64'(n_acc >= NE));
        check_val("taps3",   64'(taps3),   64'(exp_taps()));
        check_val("calc3",   64'(calc3),   64'(exp_calc3));
        check_val("primed3", 64'(primed3), 64'(n_acc >= NE));
    endtask

    // One strobe in the synchronizer build: high for hi cycles, then low for lo
    // cycles, with data held for the whole burst.
    task automatic strobe(input logic [BPE-1:0] d, input int hi, input int lo);
        for (int i = 0; i < hi; i++) step(1'b1, d, 1'b0, 1'b0);
        for (int i = 0; i < lo; i++) step(1'b0, d, 1'b0, 1'b0);
    endtask

    int             pulses;
    int             first_idx;
    logic [15:0]    mask;
    logic [BPE-1:0] rd;

    initial begin
        model_clear();
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);
        check_val("reset_taps",   64'(taps1),   64'd0);
        check_val("reset_calc",   64'(calc1),   64'd0);
        check_val("reset_primed", 64'(primed1), 64'd0);

`ifndef WAVELET_SYNC_INPUT_EN
        // Prime with 0x01..0x07; the 7th accept fires both instances.
        for (int i = 1; i <= NE; i++) step(1'b1, BPE'(i), 1'b0, 1'b0);
        check_val("prime_window", 64'(taps1), 64'h0001_0203_0405_0607);
        check_val("prime_calc",   64'(calc1), 64'd1);

        // Strobe held 4 cycles: pulse each cycle with DECIMATE=1.
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, BPE'(8'h80 + i), 1'b0, 1'b0);
            if (calc1) pulses++;
        end
        check_val("b2b_pulses", 64'(pulses),         64'd4);
        check_val("b2b_elem0",  64'(taps1[7:0]),     64'h83);
        check_val("b2b_elem3",  64'(taps1[31:24]),   64'h80);
        step(1'b0, '0, 1'b0, 1'b0);

        // Flush together with an accept: sample dropped, back to priming.
        step(1'b1, 8'h55, 1'b1, 1'b0);
        check_val("flush_taps",   64'(taps1),   64'd0);
        check_val("flush_primed", 64'(primed1), 64'd0);
        check_val("flush_calc",   64'(calc1),   64'd0);
        pulses = 0;
        for (int i = 0; i < NE - 1; i++) begin
            step(1'b1, BPE'($urandom), 1'b0, 1'b0);
            if (calc1) pulses++;
        end
        check_val("flush_no_early_pulse", 64'(pulses), 64'd0);
        step(1'b1, BPE'($urandom), 1'b0, 1'b0);
        check_val("flush_7th_pulse", 64'(calc1), 64'd1);

        // Reset mid-RUN after 5 post-priming samples.
        for (int i = 0; i < 5; i++) step(1'b1, BPE'($urandom), 1'b0, 1'b0);
        step(1'b1, 8'hAA, 1'b0, 1'b1);
        check_val("midrst_taps",   64'(taps1),   64'd0);
        check_val("midrst_primed", 64'(primed1), 64'd0);

        // DECIMATE=3 from reset: pulses on accepts 7, 10 and 13 only.
        mask = '0;
        for (int i = 1; i <= 13; i++) begin
            step(1'b1, BPE'($urandom), 1'b0, 1'b0);
            if (calc3) mask[i] = 1'b1;
        end
        check_val("dec3_pulse_mask", 64'(mask), 64'h2480);

        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 99) < 70), BPE'($urandom),
                 1'($urandom_range(0, 99) < 3), 1'($urandom_range(0, 99) < 2));
        end
`else
        // Prime with 7 short strobes.
        for (int i = 1; i <= NE; i++) strobe(BPE'(i), 1, 2);
        strobe(8'h00, 0, 3);
        check_val("prime_window", 64'(taps1), 64'h0001_0203_0405_0607);
        check_val("prime_primed", 64'(primed1), 64'd1);

        // Strobe held 10 cycles: exactly one accept, 3 edges after the rise.
        pulses = 0; first_idx = 0;
        for (int i = 1; i <= 14; i++) begin
            step(i <= 10, 8'hF0, 1'b0, 1'b0);
            if (calc1) begin
                pulses++;
                if (first_idx == 0) first_idx = i;
            end
        end
        check_val("sync_one_accept", 64'(pulses),     64'd1);
        check_val("sync_latency",    64'(first_idx),  64'd3);
        check_val("sync_elem0",      64'(taps1[7:0]), 64'hF0);

        // Random bursts with occasional flush (flush only while strobe is low).
        for (int i = 0; i < 120; i++) begin
            rd = BPE'($urandom);
            strobe(rd, $urandom_range(1, 6), $urandom_range(2, 4));
            if ($urandom_range(0, 99) < 8) step(1'b0, rd, 1'b1, 1'b0);
        end
        step(1'b0, '0, 1'b0, 1'b1);
        check_val("sync_rst_primed", 64'(primed1), 64'd0);
        for (int i = 0; i < 20; i++) strobe(BPE'($urandom), 2, 2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
